// File: rtl/display_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : display_scan_ctrl                                            |
// | Description : Time-multiplexed scan controller for an 8-digit seven-       |
// |               segment display. Cycles a 3-bit digit select, drives the     |
// |               matching active-low segments / decimal point, and holds a    |
// |               double-buffered 32-bit hex value that is swapped in only at  |
// |               a frame boundary so a frame is never torn.                   |
// | Ports       : clk, rst        - clock, synchronous active-high reset       |
// |               load, load_data, load_dp, load_ready - shadow load handshake |
// |               digit_en        - live per-digit blanking mask (bit 7=dig 0) |
// |               sel, seg, dp    - registered digit select and segment drive  |
// |               frame_done      - one-cycle pulse when the scan wraps 7->0   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module display_scan_ctrl #(
    parameter int CLK_DIV = 100000,
    parameter int CNT_W   = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [7:0]  load_dp,
    output logic        load_ready,
    input  logic [7:0]  digit_en,
    output logic [2:0]  sel,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] c_div_last = CNT_W'(CLK_DIV - 1);
    localparam logic [6:0]       c_seg_off  = 7'b1111111;
    localparam logic [6:0]       c_seg_zero = 7'b1000000;

    // Segment font, {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] f_hex_font(input logic [3:0] nib);
        logic [6:0] v;
        case (nib)
            4'h0:    v = 7'b1000000;
            4'h1:    v = 7'b1111001;
            4'h2:    v = 7'b0100100;
            4'h3:    v = 7'b0110000;
            4'h4:    v = 7'b0011001;
            4'h5:    v = 7'b0010010;
            4'h6:    v = 7'b0000010;
            4'h7:    v = 7'b1111000;
            4'h8:    v = 7'b0000000;
            4'h9:    v = 7'b0010000;
            4'hA:    v = 7'b0001000;
            4'hB:    v = 7'b0000011;
            4'hC:    v = 7'b1000110;
            4'hD:    v = 7'b0100001;
            4'hE:    v = 7'b0000110;
            default: v = 7'b0001110;
        endcase
        return v;
    endfunction

    logic [CNT_W-1:0] r_presc;
    logic [2:0]       r_sel;
    logic [31:0]      r_active;
    logic [7:0]       r_active_dp;
    logic [31:0]      r_shadow;
    logic [7:0]       r_shadow_dp;
    logic             r_pending;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_frame_done;

    logic        w_tick;
    logic        w_wrap;
    logic        w_accept;
    logic        w_transfer;
    logic [2:0]  w_sel_nxt;
    logic [31:0] w_active_nxt;
    logic [7:0]  w_active_dp_nxt;
    logic [2:0]  w_idx;
    logic [3:0]  w_nib;
    logic        w_lit;

    // The segment registers are loaded from the *next* select and *next*
    // active value so that sel, seg and dp all change on the same edge.
    always_comb begin
        w_tick          = (r_presc == c_div_last);
        w_wrap          = w_tick && (r_sel == 3'd7);
        // Accept is only possible with nothing pending, so an accept can never
        // coincide with a transfer: a load taken at the wrap tick waits a frame.
        w_accept        = load && !r_pending;
        w_transfer      = r_pending && w_wrap;
        w_sel_nxt       = w_tick ? (r_sel + 3'd1) : r_sel;
        w_active_nxt    = w_transfer ? r_shadow    : r_active;
        w_active_dp_nxt = w_transfer ? r_shadow_dp : r_active_dp;
        // Digit k lives in the high-order end: nibble [31-4k -: 4], bit 7-k.
        w_idx           = 3'd7 - w_sel_nxt;
        w_nib           = w_active_nxt[{w_idx, 2'b00} +: 4];
        w_lit           = digit_en[w_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_sel        <= 3'd0;
            r_active     <= 32'd0;
            r_active_dp  <= 8'd0;
            r_shadow     <= 32'd0;
            r_shadow_dp  <= 8'd0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_dp         <= 1'b1;
            r_seg        <= digit_en[7] ? c_seg_zero : c_seg_off;
        end else begin
            r_presc      <= w_tick ? '0 : (r_presc + 1'b1);
            r_sel        <= w_sel_nxt;
            r_frame_done <= w_wrap;
            r_active     <= w_active_nxt;
            r_active_dp  <= w_active_dp_nxt;
            if (w_accept) begin
                r_shadow    <= load_data;
                r_shadow_dp <= load_dp;
                r_pending   <= 1'b1;
            end else if (w_transfer) begin
                r_pending   <= 1'b0;
            end
            r_seg <= w_lit ? f_hex_font(w_nib) : c_seg_off;
            r_dp  <= w_lit ? ~w_active_dp_nxt[w_idx] : 1'b1;
        end
    end

    assign load_ready = ~r_pending;
    assign sel        = r_sel;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_display_scan_ctrl                                         |
// | Description : Self-checking bench for display_scan_ctrl (CLK_DIV=4).       |
// |               Directed scenarios followed by randomized traffic, checked   |
// |               every cycle against an edge-count based reference model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_display_scan_ctrl;

    localparam int c_div   = 4;
    localparam int c_frame = 8 * c_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] load_data;
    logic [7:0]  load_dp;
    logic        load_ready;
    logic [7:0]  digit_en;
    logic [2:0]  sel;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    always #5 clk = ~clk;

    display_scan_ctrl #(.CLK_DIV(c_div), .CNT_W(3)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .load_ready (load_ready),
        .digit_en   (digit_en),
        .sel        (sel),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: k counts non-reset edges since the last reset.
    // Digit shown after edge k is (k/DIV)%8; a load accepted at edge k
    // becomes visible at the first frame boundary edge strictly after k.
    logic [6:0]  font [16];
    int          k;
    logic [31:0] m_act, m_sh;
    logic [7:0]  m_act_dp, m_sh_dp;
    bit          m_pend;
    int          m_kt;

    task automatic step(input logic r, input logic l, input logic [31:0] d,
                        input logic [7:0] ddp, input logic [7:0] en);
        int         s;
        logic [3:0] nib;
        logic [6:0] e_seg;
        logic       e_dp, e_fd;
        @(negedge clk);
        rst = r; load = l; load_data = d; load_dp = ddp; digit_en = en;
        @(posedge clk);
        if (r) begin
            k = 0; m_act = 0; m_act_dp = 0; m_pend = 0;
            s = 0; e_fd = 0; e_dp = 1;
            e_seg = en[7] ? 7'b1000000 : 7'b1111111;
        end else begin
            k++;
            if (m_pend && k == m_kt) begin
                m_act = m_sh; m_act_dp = m_sh_dp; m_pend = 0;
            end else if (l && !m_pend) begin
                m_sh = d; m_sh_dp = ddp; m_pend = 1;
                m_kt = (k / c_frame + 1) * c_frame;
            end
            s    = (k / c_div) % 8;
            e_fd = (k % c_frame == 0);
            nib  = 4'((m_act >> (4 * (7 - s))) & 32'hF);
            e_seg = en[7-s] ? font[nib] : 7'b1111111;
            e_dp  = en[7-s] ? ~m_act_dp[7-s] : 1'b1;
        end
        #1;
        check("sel",        32'(sel),        32'(s));
        check("seg",        32'(seg),        32'(e_seg));
        check("dp",         32'(dp),         32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("load_ready", 32'(load_ready), 32'(!m_pend));
    endtask

    task automatic idle(input int n, input logic [7:0] en);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 8'h0, en);
    endtask

    task automatic wait_ready(input int budget);
        int i;
        for (i = 0; i < budget && m_pend; i++) idle(1, 8'hFF);
        if (i == budget) check("ready_timeout", 32'(load_ready), 32'd1);
    endtask

    initial begin
        font = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        k = 0; m_act = 0; m_sh = 0; m_act_dp = 0; m_sh_dp = 0; m_pend = 0; m_kt = 0;
        rst = 1; load = 0; load_data = 0; load_dp = 0; digit_en = 8'hFF;

        // Reset, then a couple of free-running frames.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 8'h0, 8'hFF);
        idle(70, 8'hFF);

        // Load, then a busy load that must be ignored.
        step(1'b0, 1'b1, 32'h0123ABCD, 8'h01, 8'hFF);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'hFFFFFFFF, 8'hFF, 8'hFF);
        wait_ready(2 * c_frame + 4);
        idle(c_frame + 5, 8'hFF);
        step(1'b0, 1'b1, 32'h456789EF, 8'hA5, 8'hFF);
        wait_ready(2 * c_frame + 4);

        // Blank digit 3 for two frames.
        idle(2 * c_frame, 8'b11101111);

        // Load exactly in the wrap tick cycle.
        while (k % c_frame != c_frame - 1) idle(1, 8'hFF);
        step(1'b0, 1'b1, 32'hFEDCBA98, 8'h80, 8'hFF);
        idle(2 * c_frame + 4, 8'hFF);

        // Reset while a load is pending.
        step(1'b0, 1'b1, 32'h13579BDF, 8'h3C, 8'hFF);
        idle(5, 8'hFF);
        step(1'b1, 1'b0, 32'h0, 8'h0, 8'hFF);
        step(1'b1, 1'b0, 32'h0, 8'h0, 8'hFF);
        idle(2 * c_frame + 4, 8'hFF);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic       r, l;
            logic [7:0] en;
            r  = ($urandom_range(0, 399) == 0);
            l  = ($urandom_range(0, 7) == 0);
            en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            step(r, l, $urandom, 8'($urandom), en);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
